// File: rtl/dmem_arb.sv
// dmem_arb: two-requester arbiter for the shared data RAM with lock ownership,
// a starvation bound on locks and 1-cycle read-data routing back to the issuer.
module dmem_arb #(
    parameter int DAT_W    = 32,
    parameter int ADDR_W   = 10,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DAT_W-1:0]  r0_wdat,
    output logic              r0_gnt,
    output logic              r0_rvld,
    output logic [DAT_W-1:0]  r0_rdat,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DAT_W-1:0]  r1_wdat,
    output logic              r1_gnt,
    output logic              r1_rvld,
    output logic [DAT_W-1:0]  r1_rdat,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DAT_W-1:0]  mem_wdat,
    input  logic [DAT_W-1:0]  mem_rdat
);
    typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;

    // The grant that enters OWNn is the first of the locked run, so the
    // in-ownership count breaks the lock one grant before LOCK_MAX.
    localparam logic [7:0] BRK_AT = 8'(LOCK_MAX - 1);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [1:0]  rvld_q, rvld_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic        g0, g1, own1, oth_req, own_req, own_lock, brk;

    assign g0 = !rst_b && r0_req && ((state_q == OWN0) || ((state_q == FREE) && (!r1_req || !ptr_q)));
    assign g1 = !rst_b && r1_req && ((state_q == OWN1) || ((state_q == FREE) && (!r0_req || ptr_q)));

    assign own1     = state_q == OWN1;
    assign oth_req  = own1 ? r0_req : r1_req;
    assign own_req  = own1 ? r1_req : r0_req;
    assign own_lock = own1 ? r1_lock : r0_lock;
    assign cnt_inc  = cnt_q + 8'd1;
    assign brk      = (state_q != FREE) && (g0 || g1) && oth_req && (cnt_inc >= BRK_AT);

    always_comb begin
        state_d = state_q;
        ptr_d   = g0 ? 1'b1 : g1 ? 1'b0 : ptr_q;
        cnt_d   = '0;
        rvld_d  = {g1 && !r1_we, g0 && !r0_we};
        if (state_q == FREE) begin
            state_d = (g0 && r0_lock) ? OWN0 : (g1 && r1_lock) ? OWN1 : FREE;
        end else begin
            cnt_d   = (!oth_req || brk) ? 8'd0 : (g0 || g1) ? cnt_inc : cnt_q;
            if (brk || ((g0 || g1) && !own_lock) || (!own_req && !own_lock))
                state_d = FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= FREE;
            ptr_q   <= 1'b0;
            rvld_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rvld_q  <= rvld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign r0_gnt   = g0;
    assign r1_gnt   = g1;
    assign r0_rvld  = rvld_q[0];
    assign r1_rvld  = rvld_q[1];
    assign r0_rdat  = mem_rdat;
    assign r1_rdat  = mem_rdat;
    assign mem_en   = g0 || g1;
    assign mem_we   = g0 ? r0_we : (g1 && r1_we);
    assign mem_addr = g0 ? r0_addr : g1 ? r1_addr : '0;
    assign mem_wdat = g0 ? r0_wdat : g1 ? r1_wdat : '0;
endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed checks of dmem_arb against a simple 1-cycle RAM.
module tb_dmem_arb;
    logic        clk = 1'b0;
    logic        rst_b;
    logic        r0_req, r0_we, r0_lock, r0_gnt, r0_rvld;
    logic        r1_req, r1_we, r1_lock, r1_gnt, r1_rvld;
    logic [9:0]  r0_addr, r1_addr, mem_addr;
    logic [31:0] r0_wdat, r1_wdat, r0_rdat, r1_rdat, mem_wdat, mem_rdat;
    logic        mem_en, mem_we;
    logic [31:0] ram [0:1023];
    int          checks = 0;
    int          failures = 0;
    logic [2:0]  v5b [4] = '{3'b110, 3'b011, 3'b001, 3'b001};
    logic [1:0]  e5b [4] = '{2'b10, 2'b00, 2'b00, 2'b01};

    dmem_arb #(.DAT_W(32), .ADDR_W(10), .LOCK_MAX(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdat(r0_wdat),
        .r0_gnt(r0_gnt), .r0_rvld(r0_rvld), .r0_rdat(r0_rdat),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdat(r1_wdat),
        .r1_gnt(r1_gnt), .r1_rvld(r1_rvld), .r1_rdat(r1_rdat),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdat;
            mem_rdat <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h1000_0000 + i;
        mem_rdat = '0;
        {r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock} = '0;
        {r0_addr, r1_addr, r0_wdat, r1_wdat} = '0;
        rst_b = 1'b1;
        cyc;
        r0_req = 1'b1;
        #4 check("rst_gnt", 32'({r0_gnt, r1_gnt, mem_en, mem_we}), 32'd0);
        cyc;
        rst_b = 1'b0;
        r0_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #4 check("idle", 32'({r0_gnt, r1_gnt, r0_rvld, r1_rvld, mem_en, mem_we}), 32'd0);
            cyc;
        end

        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 10'h005; r1_wdat = 32'hDEADBEEF;
        #4 check("wr_gnt", 32'({r0_gnt, r1_gnt}), 32'd1);
        check("wr_mem", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b1, 10'h005}));
        check("wr_wdat", mem_wdat, 32'hDEADBEEF);
        cyc;
        r1_req = 1'b0; r1_we = 1'b0; r0_req = 1'b1; r0_addr = 10'h005;
        #4 check("rd_gnt", 32'({r0_gnt, r1_gnt}), 32'd2);
        check("rd_mem", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 10'h005}));
        check("wr_no_rvld", 32'({r0_rvld, r1_rvld}), 32'd0);
        cyc;
        r0_req = 1'b0;
        #4 check("rd_rvld", 32'({r0_rvld, r1_rvld}), 32'd2);
        check("rd_rdat", r0_rdat, 32'hDEADBEEF);
        check("rd_idle", 32'({r0_gnt, r1_gnt, mem_en}), 32'd0);

        cyc;
        rst_b = 1'b1;
        cyc;
        rst_b = 1'b0;
        r0_req = 1'b1; r1_req = 1'b1; r0_addr = 10'd1; r1_addr = 10'd2;
        for (int k = 0; k < 4; k++) begin
            #4 check("rr_gnt", 32'({r0_gnt, r1_gnt}), (k % 2 == 0) ? 32'd2 : 32'd1);
            check("rr_rvld", 32'({r0_rvld, r1_rvld}), (k == 0) ? 32'd0 : (k % 2 == 1) ? 32'd2 : 32'd1);
            if (k > 0)
                check("rr_rdat", (k % 2 == 1) ? r0_rdat : r1_rdat, (k % 2 == 1) ? 32'h1000_0001 : 32'h1000_0002);
            cyc;
        end
        r0_req = 1'b0; r1_req = 1'b0;
        #4 check("rr_last_rvld", 32'({r0_rvld, r1_rvld}), 32'd1);
        check("rr_last_rdat", r1_rdat, 32'h1000_0002);

        for (int k = 0; k < 4; k++) begin
            cyc;
            r0_req = k < 3; r0_lock = k < 2; r1_req = 1'b1;
            #4 check("lock3_gnt", 32'({r0_gnt, r1_gnt}), (k < 3) ? 32'd2 : 32'd1);
        end
        cyc;
        r0_req = 1'b0; r0_lock = 1'b0; r1_req = 1'b0;

        for (int k = 0; k < 7; k++) begin
            cyc;
            r0_req = 1'b1; r0_lock = k < 5; r1_req = 1'b1;
            #4 check("starve_gnt", 32'({r0_gnt, r1_gnt}), (k < 4 || k == 5) ? 32'd2 : 32'd1);
        end
        cyc;
        r0_req = 1'b0; r0_lock = 1'b0; r1_req = 1'b0;

        for (int k = 0; k < 4; k++) begin
            cyc;
            {r0_req, r0_lock, r1_req} = v5b[k];
            #4 check("own_idle_gnt", 32'({r0_gnt, r1_gnt}), 32'(e5b[k]));
        end
        cyc;
        r1_req = 1'b0;

        r0_req = 1'b1; r0_lock = 1'b1; r0_addr = 10'd3;
        #4 check("rstg_a_gnt", 32'({r0_gnt, r1_gnt}), 32'd2);
        cyc;
        rst_b = 1'b1;
        #4 check("rstg_b_gnt", 32'({r0_gnt, r1_gnt, mem_en, mem_we}), 32'd0);
        check("rstg_b_rvld", 32'({r0_rvld, r1_rvld}), 32'd2);
        check("rstg_b_rdat", r0_rdat, 32'h1000_0003);
        cyc;
        rst_b = 1'b0; r0_req = 1'b0; r1_req = 1'b1;
        #4 check("rstg_c_rvld", 32'({r0_rvld, r1_rvld}), 32'd0);
        check("rstg_c_gnt", 32'({r0_gnt, r1_gnt}), 32'd1);
        cyc;
        r1_req = 1'b0; r0_lock = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
